// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Holds CLK low to inhibit, requests to send
// with the start bit on DAT, then shifts one byte (LSB first), odd parity and
// stop on device-generated CLK falls, samples the device ACK and waits for
// both lines to return high. A watchdog aborts the transfer when the device
// stops clocking. Outputs are registered open-drain pull-down enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT = 2500,
  parameter int unsigned TIMEOUT = 375000,
  parameter int unsigned FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clk,
  input  logic       ps_dat,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
  localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);
  localparam logic          INH_ONE  = (INHIBIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_ACK,
    S_WAITHI
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_fcnt;
  logic          w_fall;

  state_t        r_state, w_state_n;
  logic [7:0]    r_data, w_data_n;
  logic [3:0]    r_bit, w_bit_n;
  logic [TW-1:0] r_cnt, w_cnt_n;
  logic [IW-1:0] r_inh, w_inh_n;
  logic          r_clk_oe, w_clk_oe_n;
  logic          r_dat_oe, w_dat_oe_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic          r_error, w_error_n;
  logic          w_tx_bit;
  logic          w_watch;
  logic          w_timeout;

  // Two-stage synchronizers for the asynchronous pin levels (idle high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // CLK deglitch: the filtered level follows only after FILTER equal samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_filt <= 1'b1;
      r_fcnt     <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FLT_LAST) begin
      r_clk_filt <= r_clk_s2;
      r_fcnt     <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_fall = r_clk_filt & ~r_clk_s2 & (r_fcnt == FLT_LAST);

  // Bit placed on DAT for frame position r_bit: data, odd parity, stop.
  always_comb begin
    w_tx_bit = 1'b1;
    case (r_bit)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: w_tx_bit = r_data[r_bit[2:0]];
      4'd8:                   w_tx_bit = ~^r_data;
      default:                w_tx_bit = 1'b1;
    endcase
  end

  // FSM state, frame registers and registered line/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_inh    <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_data   <= w_data_n;
      r_bit    <= w_bit_n;
      r_cnt    <= w_cnt_n;
      r_inh    <= w_inh_n;
      r_clk_oe <= w_clk_oe_n;
      r_dat_oe <= w_dat_oe_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_error  <= w_error_n;
    end
  end

  // Next-state and next-output logic; the watchdog abort overrides the state
  // decisions in every device-clocked state.
  always_comb begin
    w_state_n  = r_state;
    w_data_n   = r_data;
    w_bit_n    = r_bit;
    w_cnt_n    = r_cnt;
    w_inh_n    = r_inh;
    w_clk_oe_n = r_clk_oe;
    w_dat_oe_n = r_dat_oe;
    w_busy_n   = r_busy;
    w_done_n   = 1'b0;
    w_error_n  = r_error;

    w_watch   = (r_state == S_REQ) || (r_state == S_DATA) ||
                (r_state == S_ACK) || (r_state == S_WAITHI);
    w_timeout = w_watch && !w_fall && (r_cnt == TO_LAST);

    if (w_watch) begin
      w_cnt_n = w_fall ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_clk_oe_n = 1'b0;
        w_dat_oe_n = 1'b0;
        if (start && !r_done) begin
          w_data_n   = data;
          w_busy_n   = 1'b1;
          w_error_n  = 1'b0;
          w_inh_n    = '0;
          w_clk_oe_n = 1'b1;
          w_dat_oe_n = INH_ONE;
          w_state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh == INH_LAST) begin
          w_clk_oe_n = 1'b0;
          w_dat_oe_n = 1'b1;
          w_cnt_n    = '0;
          w_bit_n    = '0;
          w_state_n  = S_REQ;
        end else begin
          w_inh_n    = r_inh + 1'b1;
          w_clk_oe_n = 1'b1;
          w_dat_oe_n = (r_inh == INH_LAST - 1'b1);
        end
      end
      S_REQ, S_DATA: begin
        if (w_fall) begin
          if (r_bit == 4'd9) begin
            w_dat_oe_n = 1'b0;
            w_state_n  = S_ACK;
          end else begin
            w_dat_oe_n = ~w_tx_bit;
            w_bit_n    = r_bit + 4'd1;
            w_state_n  = S_DATA;
          end
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_error_n = r_dat_s2;
          w_state_n = S_WAITHI;
        end
      end
      S_WAITHI: begin
        if (r_clk_filt && r_dat_s2) begin
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_timeout) begin
      w_clk_oe_n = 1'b0;
      w_dat_oe_n = 1'b0;
      w_error_n  = 1'b1;
      w_done_n   = 1'b1;
      w_busy_n   = 1'b0;
      w_state_n  = S_IDLE;
    end
  end

  assign clk_oe = r_clk_oe;
  assign dat_oe = r_dat_oe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign error  = r_error;

endmodule
